// File: rtl/axis_fifo_drain_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_fifo_drain_pkg : shared widths and defaults for the FIFO drain path |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package axis_fifo_drain_pkg;
    localparam int DATA_W_DEF    = 16;
    localparam int FRAME_LEN_DEF = 8;
    localparam int FRAME_CNT_W   = 16;
    localparam int BEAT_W        = 16;
endpackage
`default_nettype wire

// File: rtl/axis_fifo_drain_stream_buf2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_buf2 : 2-entry in-order valid/ready buffer with occupancy output  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module stream_buf2 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occ
);
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        w_kept;

    always_comb begin
        occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
        head_d = head_q;
        tail_d = tail_q;
        w_kept = occ_q - {1'b0, pop};
        if (pop) begin
            head_d = tail_q;
        end
        // The incoming word lands in the first slot left free after the pop.
        if (push) begin
            if (w_kept == 2'd0) begin
                head_d = push_data;
            end else begin
                tail_d = push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && occ_q == 2'd2));
        end
    end

    assign valid     = (occ_q != 2'd0);
    assign head_data = head_q;
    assign occ       = occ_q;
endmodule
`default_nettype wire

// File: rtl/axis_fifo_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_fifo_drain : pops the async FIFO read port into a framed stream     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module axis_fifo_drain
    import axis_fifo_drain_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                   rd_clk,
    input  logic                   reset,
    input  logic                   drain_en,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [DATA_W-1:0]      fifo_rd_data,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic                   m_tlast,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   idle
);
    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    logic [1:0]             occ;
    logic                   inflight_q, inflight_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   w_pop;
    logic                   w_rd_en;
    logic                   w_last_beat;
    logic [2:0]             w_backlog;

    always_comb begin
        w_pop       = m_tvalid && m_tready;
        // Words held or returning after this cycle's pop; a read is only
        // issued when its word is guaranteed a free slot on arrival.
        w_backlog   = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, w_pop};
        w_rd_en     = !reset && drain_en && !fifo_empty && (w_backlog <= 3'd1);
        w_last_beat = (beat_q == C_LAST_BEAT);
        inflight_d  = w_rd_en;
        beat_d      = beat_q;
        frame_cnt_d = frame_cnt_q;
        if (w_pop) begin
            if (w_last_beat) begin
                beat_d      = '0;
                frame_cnt_d = frame_cnt_q + 1'b1;
            end else begin
                beat_d      = beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            inflight_q  <= 1'b0;
            beat_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            beat_q      <= beat_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    stream_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (rd_clk),
        .rst       (reset),
        .push      (inflight_q),
        .push_data (fifo_rd_data),
        .pop       (w_pop),
        .valid     (m_tvalid),
        .head_data (m_tdata),
        .occ       (occ)
    );

    assign fifo_rd_en = w_rd_en;
    assign m_tlast    = m_tvalid && w_last_beat;
    assign frame_cnt  = frame_cnt_q;
    assign idle       = (occ == 2'd0) && !inflight_q;
endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axis_fifo_drain : randomized and directed bench with a word-queue model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_axis_fifo_drain;
    localparam int DW = 16;
    localparam int FL = 8;

    logic          rd_clk = 1'b0;
    logic          reset;
    logic          drain_en;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic [15:0]   frame_cnt;
    logic          idle;

    always #5 rd_clk = ~rd_clk;

    axis_fifo_drain #(
        .DATA_W    (DW),
        .FRAME_LEN (FL)
    ) dut (
        .rd_clk       (rd_clk),
        .reset        (reset),
        .drain_en     (drain_en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .frame_cnt    (frame_cnt),
        .idle         (idle)
    );

    typedef struct {
        logic [DW-1:0] d;
        int            vis;
    } item_t;

    logic [DW-1:0] fifo_q[$];
    item_t         out_q[$];
    int            cyc;
    int            beats;
    int            rd_seen;
    int            checks;
    int            failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs were set after the previous edge.
    task automatic tick();
        logic    exp_valid;
        logic    exp_pop;
        logic    exp_rd;
        logic    rd;
        int      outst;
        item_t   it;
        fifo_empty = (fifo_q.size() == 0);
        #1;
        outst     = out_q.size();
        exp_valid = (outst > 0) && (out_q[0].vis <= cyc);
        exp_pop   = exp_valid && m_tready;
        exp_rd    = drain_en && !fifo_empty && ((outst - (exp_pop ? 1 : 0)) <= 1);
        chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
        chk("tvalid", {31'd0, m_tvalid}, {31'd0, exp_valid});
        chk("idle", {31'd0, idle}, {31'd0, outst == 0});
        chk("outstanding_le2", {31'd0, outst <= 2}, 32'd1);
        chk("frame_cnt", {16'd0, frame_cnt}, (beats / FL) % 65536);
        if (exp_valid) begin
            chk("tdata", {16'd0, m_tdata}, {16'd0, out_q[0].d});
            chk("tlast", {31'd0, m_tlast}, {31'd0, (beats % FL) == FL - 1});
        end
        rd = fifo_rd_en;
        if (rd) rd_seen++;
        if (exp_pop) begin
            void'(out_q.pop_front());
            beats++;
        end
        @(posedge rd_clk);
        cyc++;
        #1;
        if (rd && fifo_q.size() > 0) begin
            it.d         = fifo_q.pop_front();
            it.vis       = cyc + 1;
            fifo_rd_data = it.d;
            out_q.push_back(it);
        end else begin
            fifo_rd_data = DW'($urandom);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'(first + i));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, {31'd0, m_tvalid}, 32'd0);
        chk({tag, "_tdata"}, {16'd0, m_tdata}, 32'd0);
        chk({tag, "_tlast"}, {31'd0, m_tlast}, 32'd0);
        chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
        chk({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
        chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        out_q.delete();
        beats = 0;
        @(posedge rd_clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        beats        = 0;
        rd_seen      = 0;
        reset        = 1'b1;
        drain_en     = 1'b1;
        m_tready     = 1'b0;
        fifo_rd_data = '0;
        push_seq(16'h00A0, 3);
        fifo_empty   = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge rd_clk);
        @(posedge rd_clk);
        #1;
        fifo_q.delete();
        reset = 1'b0;

        // Full-rate frame of 1..8.
        push_seq(1, 8);
        m_tready = 1'b1;
        rd_seen  = 0;
        ticks(14);
        chk("burst_rd_count", rd_seen, 32'd8);
        chk("burst_frames", {16'd0, frame_cnt}, 32'd1);

        // Sink ready toggling each cycle.
        push_seq(1, 8);
        for (int i = 0; i < 24; i++) begin
            m_tready = i[0];
            tick();
        end
        chk("toggle_frames", {16'd0, frame_cnt}, 32'd2);

        // Sink stalled: exactly two reads, then drain.
        chk("stall_start_idle", {31'd0, idle}, 32'd1);
        push_seq(16'h0100, 6);
        m_tready = 1'b0;
        rd_seen  = 0;
        ticks(6);
        chk("stall_rd_count", rd_seen, 32'd2);
        m_tready = 1'b1;
        ticks(12);

        // drain_en dropped right after a read issues.
        push_seq(16'h0200, 4);
        tick();
        chk("drop_issue", rd_seen > 0, 32'd1);
        drain_en = 1'b0;
        rd_seen  = 0;
        ticks(6);
        chk("drop_no_reads", rd_seen, 32'd0);
        chk("drop_idle", {31'd0, idle}, 32'd1);

        // FIFO runs empty mid-frame.
        fifo_q.delete();
        do_reset();
        drain_en = 1'b1;
        push_seq(16'h0300, 5);
        ticks(10);
        push_seq(16'h0305, 3);
        ticks(8);
        chk("gap_frames", {16'd0, frame_cnt}, 32'd1);

        // Reset while the buffer is full and a read is in flight.
        push_seq(16'h0400, 6);
        m_tready = 1'b0;
        ticks(5);
        m_tready = 1'b1;
        tick();
        do_reset();
        push_seq(16'h0500, 8);
        ticks(16);
        chk("post_reset_frames", {16'd0, frame_cnt}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            m_tready = ($urandom_range(0, 3) != 0);
            drain_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) != 0) fifo_q.push_back(DW'($urandom));
            tick();
        end
        m_tready = 1'b1;
        drain_en = 1'b1;
        for (int i = 0; i < 600 && (fifo_q.size() > 0 || out_q.size() > 0); i++) tick();
        chk("final_drained", {31'd0, fifo_q.size() == 0 && out_q.size() == 0}, 32'd1);
        tick();
        chk("final_idle", {31'd0, idle}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
